// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a row of up to six 7-segment digits. A
// SCAN_EXP-bit prescaler produces a scan tick every 2^SCAN_EXP clocks. On
// each tick the driver selects the next digit position and registers that
// digit's segment pattern and decimal point. A free-running BLINK_EXP-bit
// counter supplies the blink phase for digits flagged in blink_mask.
//
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
// Without the macro, zero digits display as the normal '0' pattern.
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       asynchronous, active-low reset
//   bcd_in      digit k at bits [4k+3:4k], digit 0 is rightmost
//   dp_in       decimal-point request, bit k for digit k
//   blink_mask  bit k = 1 blinks digit k
//   enable      0 blanks segments and decimal point from the next tick on
//   seg7_sel    selected position, digit k is presented as code 5-k
//   seg7_out    segments abcdefg, active-high
//   dpt_out     decimal point, active-high
//   led_com     common line, tied to 1
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIG   = 6,
  parameter int SCAN_EXP  = 17,
  parameter int BLINK_EXP = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] bcd_in,
  input  logic [5:0]  dp_in,
  input  logic [5:0]  blink_mask,
  input  logic        enable,
  output logic [2:0]  seg7_sel,
  output logic [6:0]  seg7_out,
  output logic        dpt_out,
  output logic        led_com
);

  // Position codes run downwards: digit 0 is code 5, digit NUM_DIG-1 is the
  // last code visited before wrapping back to 5.
  localparam logic [2:0] SEL_FIRST = 3'd5;
  localparam logic [2:0] SEL_LAST  = 3'(6 - NUM_DIG);

  logic [SCAN_EXP-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [BLINK_EXP-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]           sel_q,       sel_d;
  logic [6:0]           seg_q,       seg_d;
  logic                 dp_q,        dp_d;

  logic       scan_tick;
  logic [2:0] sel_step;
  logic [2:0] dig_idx;
  logic [3:0] digit_arr [6];
  logic [5:0] lzb;
  logic       blank;

  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

`ifdef SEG7_LZB_EN
  // A digit above position 0 is blanked when it and every populated digit
  // to its left are zero; the scan runs from the leftmost digit inwards.
  logic zeros_above;
  always_comb begin
    zeros_above = 1'b1;
    lzb         = '0;
    for (int k = 5; k >= 1; k--) begin
      if (k < NUM_DIG) begin
        zeros_above = zeros_above && (bcd_in[4*k +: 4] == 4'd0);
        lzb[k]      = zeros_above;
      end
    end
  end
`else
  assign lzb = '0;
`endif

  assign scan_tick = &scan_cnt_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is
    // inferred; state holds by reassigning the current flop value.
    scan_cnt_d  = scan_cnt_q + 1'b1;
    blink_cnt_d = blink_cnt_q + 1'b1;
    sel_d       = sel_q;
    seg_d       = seg_q;
    dp_d        = dp_q;

    for (int k = 0; k < 6; k++) begin
      digit_arr[k] = bcd_in[4*k +: 4];
    end

    // The outputs are computed for the digit that becomes selected on this
    // edge, so position and pattern change together.
    sel_step = (sel_q == SEL_LAST) ? SEL_FIRST : sel_q - 3'd1;
    dig_idx  = SEL_FIRST - sel_step;
    blank    = !enable || (blink_cnt_q[BLINK_EXP-1] && blink_mask[dig_idx]);

    if (scan_tick) begin
      sel_d = sel_step;
      seg_d = (blank || lzb[dig_idx]) ? 7'b0000000 : decode_bcd(digit_arr[dig_idx]);
      dp_d  = !blank && dp_in[dig_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every flop here is control or output state with a defined
      // power-up value, so all of them are reset.
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      sel_q       <= SEL_FIRST;
      seg_q       <= 7'b0000000;
      dp_q        <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign seg7_sel = sel_q;
  assign seg7_out = seg_q;
  assign dpt_out  = dp_q;
  assign led_com  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench. A three-digit instance (SCAN_EXP=2, BLINK_EXP=4) is
// the main target; a one-digit instance shares the same inputs. Expected
// tick results are predicted from the inputs when a tick is requested,
// pushed to a scoreboard queue and popped when the tick edge has passed.
// Honours SEG7_LZB_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int NUM_DIG   = 3;
  localparam int SCAN_EXP  = 2;
  localparam int BLINK_EXP = 4;

  logic        clk;
  logic        reset;
  logic [23:0] bcd_in;
  logic [5:0]  dp_in;
  logic [5:0]  blink_mask;
  logic        enable;

  logic [2:0]  seg7_sel,   seg7_sel_1;
  logic [6:0]  seg7_out,   seg7_out_1;
  logic        dpt_out,    dpt_out_1;
  logic        led_com,    led_com_1;

  seg7_scan_driver #(.NUM_DIG(NUM_DIG), .SCAN_EXP(SCAN_EXP), .BLINK_EXP(BLINK_EXP)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .enable     (enable),
    .seg7_sel   (seg7_sel),
    .seg7_out   (seg7_out),
    .dpt_out    (dpt_out),
    .led_com    (led_com)
  );

  seg7_scan_driver #(.NUM_DIG(1), .SCAN_EXP(SCAN_EXP), .BLINK_EXP(BLINK_EXP)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .enable     (enable),
    .seg7_sel   (seg7_sel_1),
    .seg7_out   (seg7_out_1),
    .dpt_out    (dpt_out_1),
    .led_com    (led_com_1)
  );

  typedef struct {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic [6:0] seg1;
    logic       dp1;
  } exp_t;

  exp_t sb_q[$];
  exp_t last;
  int   tick_m;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Prediction for tick number m after reset release. Tick m lands on clock
  // edge 4m; the blink counter seen at that edge holds 4m-1 (mod 16).
  function automatic exp_t predict(input int m);
    exp_t e;
    int   k;
    logic blink_on, blank, blank1, lz;
    k        = m % NUM_DIG;
    blink_on = ((4 * m - 1) % 16) >= 8;
    blank    = !enable || (blink_on && blink_mask[k]);
    lz       = 1'b0;
`ifdef SEG7_LZB_EN
    if (k > 0) begin
      lz = 1'b1;
      for (int j = k; j < NUM_DIG; j++) begin
        if (bcd_in[4*j +: 4] != 4'd0) lz = 1'b0;
      end
    end
`endif
    e.sel  = 3'(5 - k);
    e.seg  = (blank || lz) ? 7'b0000000 : seg_pat(bcd_in[4*k +: 4]);
    e.dp   = !blank && dp_in[k];
    blank1 = !enable || (blink_on && blink_mask[0]);
    e.seg1 = blank1 ? 7'b0000000 : seg_pat(bcd_in[3:0]);
    e.dp1  = !blank1 && dp_in[0];
    return e;
  endfunction

  task automatic clear_last();
    last.sel  = 3'd5;
    last.seg  = 7'b0000000;
    last.dp   = 1'b0;
    last.seg1 = 7'b0000000;
    last.dp1  = 1'b0;
    tick_m    = 0;
  endtask

  // Called at a negedge just after the previous tick (or reset release).
  // Three edges must hold the outputs, the fourth must deliver the tick.
  task automatic do_tick();
    exp_t e;
    sb_q.push_back(predict(tick_m + 1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_sel", 32'(seg7_sel), 32'(last.sel));
      check("hold_seg", 32'(seg7_out), 32'(last.seg));
    end
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("t%0d_sel", tick_m + 1), 32'(seg7_sel), 32'(e.sel));
    check($sformatf("t%0d_seg", tick_m + 1), 32'(seg7_out), 32'(e.seg));
    check($sformatf("t%0d_dp", tick_m + 1), 32'(dpt_out), 32'(e.dp));
    check($sformatf("t%0d_sel1", tick_m + 1), 32'(seg7_sel_1), 32'(3'd5));
    check($sformatf("t%0d_seg1", tick_m + 1), 32'(seg7_out_1), 32'(e.seg1));
    check($sformatf("t%0d_dp1", tick_m + 1), 32'(dpt_out_1), 32'(e.dp1));
    check("led_com", 32'(led_com), 32'(1'b1));
    last = e;
    tick_m++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sel"}, 32'(seg7_sel), 32'(3'b101));
    check({tag, "_seg"}, 32'(seg7_out), 32'(7'b0000000));
    check({tag, "_dp"}, 32'(dpt_out), 32'(1'b0));
    check({tag, "_com"}, 32'(led_com), 32'(1'b1));
    check({tag, "_sel1"}, 32'(seg7_sel_1), 32'(3'b101));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    bcd_in     = 24'h000321;
    dp_in      = 6'b000000;
    blink_mask = 6'b000000;
    enable     = 1'b1;
    clear_last();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset = 1'b1;

    // Basic scan 4,3,5,4 with digits 2,3,1,2.
    for (int i = 0; i < 4; i++) do_tick();

    // Code 12 on digit 1 decodes blank while its decimal point still shows.
    bcd_in = 24'h0000C1;
    dp_in  = 6'b000010;
    for (int i = 0; i < 3; i++) do_tick();

    // Zeros above the rightmost digit; unused digit bits set to junk.
    bcd_in     = 24'h987007;
    dp_in      = 6'b111000;
    blink_mask = 6'b111000;
    for (int i = 0; i < 3; i++) do_tick();

    // Enable dropped for two ticks, then restored.
    bcd_in     = 24'h000321;
    dp_in      = 6'b000111;
    blink_mask = 6'b000000;
    do_tick();
    enable = 1'b0;
    do_tick();
    do_tick();
    enable = 1'b1;
    do_tick();

    // Blink on digit 0 across several blink phases (ticks 15..25).
    blink_mask = 6'b000001;
    dp_in      = 6'b000001;
    for (int i = 0; i < 11; i++) do_tick();

    // Tick 25 left sel=4; reset mid-scan, one edge into the hold period.
    check("pre_rst_sel", 32'(seg7_sel), 32'(3'd4));
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b1;
    clear_last();
    for (int i = 0; i < 3; i++) do_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIG, default 6: number of scanned digits, legal range 1..6.
REQ-002 Parameter SCAN_EXP, default 17: one scan tick every 2^SCAN_EXP clk cycles.
REQ-003 Parameter BLINK_EXP, default 24: blink phase is bit BLINK_EXP-1 of a free-running counter.
REQ-004 clk  input  1  single system clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 bcd_in  input  24  digit k at bits [4k+3:4k]; digit 0 is the rightmost digit.
REQ-007 dp_in  input  6  decimal-point request, bit k for digit k.
REQ-008 blink_mask  input  6  bit k=1 blinks digit k.
REQ-009 enable  input  1  display enable; 0 blanks all segments.
REQ-010 seg7_sel  output  3  selected digit position; digit k maps to code 5-k.
REQ-011 seg7_out  output  7  segments abcdefg, active-high.
REQ-012 dpt_out  output  1  decimal point, active-high.
REQ-013 led_com  output  1  constant 1.

Function
REQ-014 Prescaler: SCAN_EXP-bit counter, increments every clk, wraps; scan tick asserted when its value is all ones.
REQ-015 On a scan-tick edge, seg7_sel steps 5,4,...,6-NUM_DIG, then wraps to 5; without a tick it holds.
REQ-016 seg7_out and dpt_out are registered and update on the same edge as seg7_sel, from inputs sampled at that edge for the newly selected digit; they hold between ticks.
REQ-017 Decode: 0-9 use standard patterns (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011); codes 10-15 give 0000000.
REQ-018 dpt_out = dp_in[k] for the selected digit k, subject to REQ-019 and REQ-020.
REQ-019 Blink counter: BLINK_EXP-bit, free-running, wraps; when its MSB=1 and blink_mask[k]=1, digit k drives seg7_out=0 and dpt_out=0.
REQ-020 enable=0 forces seg7_out=0 and dpt_out=0 at the next tick; scanning and both counters continue.
REQ-021 Digits with index >= NUM_DIG are never selected, and their bcd_in, dp_in and blink_mask bits are ignored.
REQ-022 NUM_DIG=1: seg7_sel stays 5, and outputs still refresh on every tick.

Reset
REQ-023 reset=0 immediately forces: prescaler=0, blink counter=0, seg7_sel=3'b101, seg7_out=0000000, dpt_out=0; led_com stays 1.
REQ-024 Reset asserted mid-scan aborts the scan; after release, the first tick occurs 2^SCAN_EXP clk edges later and selects code 4 (or 5 when NUM_DIG=1).

Configuration
REQ-025 Macro SEG7_LZB_EN defined: leading-zero blanking is on; digit k>0 drives seg7_out=0 when it and all digits k+1..NUM_DIG-1 equal 0. Digit 0 is never blanked, and dpt_out is unaffected by this rule.
REQ-026 SEG7_LZB_EN undefined: no leading-zero logic; zeros display as 1111110.

Verification
REQ-027 Bench with SCAN_EXP=2, NUM_DIG=3, enable=1, bcd_in=0x000321, blink_mask=0: seg7_sel sequence 5,4,3,5 every 4 clk, with seg7_out 0110000, 1101101, 1111001.
REQ-028 SEG7_LZB_EN defined, bcd_in=0x000007, NUM_DIG=3: sel 5 -> 1110000, sel 4 -> 0000000, sel 3 -> 0000000. Without the macro, sel 4 and sel 3 -> 1111110.
REQ-029 bcd_in digit 1 = 4'hC, dp_in=6'b000010: sel 4 -> seg7_out 0000000 and dpt_out 1.
REQ-030 BLINK_EXP=4, blink_mask=6'b000001: digit 0 is blank while the blink counter >= 8 and shows its pattern while it is < 8.
REQ-031 enable dropped mid-scan: the next tick gives seg7_out=0; seg7_sel keeps stepping; raising enable restores the pattern on the following tick.
REQ-032 reset pulsed low while sel=4: outputs go to 3'b101 / 0 asynchronously; the first tick after release occurs 4 clk later with sel=4.
